// File: rtl/rr_arbiter_8_pkg.sv
// Shared definitions for the 8-way round-robin arbiter: FSM encoding, default hold limit
// and the rotating-priority winner search.
package rr_arbiter_8_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam int HOLD_MAX_DEF = 15;

  // First requester at or after ptr, wrapping modulo 8; returns ptr when req is empty.
  function automatic logic [2:0] rr_pick(input logic [7:0] req, input logic [2:0] ptr);
    logic [2:0] idx;
    logic       found;
    rr_pick = ptr;
    found   = 1'b0;
    for (int i = 0; i < 8; i++) begin
      idx = ptr + 3'(i);
      if (!found && req[idx]) begin
        rr_pick = idx;
        found   = 1'b1;
      end
    end
  endfunction

endpackage

// File: rtl/rr_arbiter_8_dec.sv
// Combinational 3-to-8 one-hot decoder; output is all zeros when en is low.
module dec_3to8 (
  input  logic [2:0] idx,
  input  logic       en,
  output logic [7:0] onehot
);

  always_comb begin
    onehot = '0;
    if (en) onehot[idx] = 1'b1;
  end

endmodule

// File: rtl/rr_arbiter_8.sv
// Round-robin arbiter for 8 requesters; a grant lasts until release, request drop,
// or HOLD_MAX+1 cycles, and every grant is followed by at least one IDLE cycle.
module rr_arbiter_8
  import rr_arbiter_8_pkg::*;
#(
  parameter int HOLD_MAX = HOLD_MAX_DEF,
  parameter int CNT_W    = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req,
  input  logic       release_i,
  output logic [7:0] grant,
  output logic [2:0] grant_idx,
  output logic       grant_valid,
  output logic       timeout
);

  state_t           state, state_d;
  logic [2:0]       ptr, ptr_d;
  logic [CNT_W-1:0] hold_cnt, cnt_d;
  logic [2:0]       idx_d;
  logic             timeout_d;
  logic [2:0]       winner;

  assign winner = rr_pick(req, ptr);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= '0;
      hold_cnt  <= '0;
      grant_idx <= '0;
      timeout   <= 1'b0;
    end else begin
      state     <= state_d;
      ptr       <= ptr_d;
      hold_cnt  <= cnt_d;
      grant_idx <= idx_d;
      timeout   <= timeout_d;
    end
  end

  always_comb begin
    state_d   = state;
    ptr_d     = ptr;
    cnt_d     = hold_cnt;
    idx_d     = grant_idx;
    timeout_d = 1'b0;
    case (state)
      IDLE: begin
        if (|req) begin
          state_d = GRANT;
          idx_d   = winner;
          cnt_d   = '0;
          ptr_d   = winner + 3'd1;
        end
      end
      GRANT: begin
        // Voluntary end beats the hold limit, so a release at the limit never pulses timeout.
        if (release_i || !req[grant_idx]) begin
          state_d = IDLE;
        end else if (hold_cnt == CNT_W'(HOLD_MAX)) begin
          state_d   = IDLE;
          timeout_d = 1'b1;
        end else begin
          cnt_d = hold_cnt + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign grant_valid = (state == GRANT);

  dec_3to8 u_dec (
    .idx    (grant_idx),
    .en     (grant_valid),
    .onehot (grant)
  );

endmodule

// File: tb/tb_rr_arbiter_8.sv
// Scoreboarded directed test of rr_arbiter_8 (HOLD_MAX=15): reset, fairness, wrap,
// timeout, request drop, release at the limit and mid-grant reset.
module tb_rr_arbiter_8;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] req;
  logic       release_i;
  logic [7:0] grant;
  logic [2:0] grant_idx;
  logic       grant_valid;
  logic       timeout;

  typedef struct {
    logic [7:0] g;
    logic [2:0] idx;
    logic       v;
    logic       to;
    int         id;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   errors  = 0;
  int   vec_id  = 0;

  always #5 clk = ~clk;

  rr_arbiter_8 dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .release_i   (release_i),
    .grant       (grant),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid),
    .timeout     (timeout)
  );

  // Drive one cycle of inputs, then queue the outputs expected after that edge.
  task automatic tick(input logic r, input logic [7:0] q, input logic rl,
                      input logic [7:0] eg, input logic [2:0] ei,
                      input logic ev, input logic et);
    exp_t e;
    rst       = r;
    req       = q;
    release_i = rl;
    @(posedge clk);
    #1;
    e.g   = eg;
    e.idx = ei;
    e.v   = ev;
    e.to  = et;
    e.id  = vec_id;
    sb.push_back(e);
    vec_id++;
  endtask

  always @(negedge clk) begin
    if (sb.size() != 0) begin
      exp_t e;
      e = sb.pop_front();
      vectors++;
      if (grant !== e.g || grant_idx !== e.idx || grant_valid !== e.v || timeout !== e.to) begin
        errors++;
        $display("FAIL vec%0d: got grant=%h idx=%0d valid=%b timeout=%b, want grant=%h idx=%0d valid=%b timeout=%b",
                 e.id, grant, grant_idx, grant_valid, timeout, e.g, e.idx, e.v, e.to);
      end
    end
  end

  initial begin
    rst       = 1'b1;
    req       = '0;
    release_i = 1'b0;

    // Reset held two cycles with all requesters active, then first grant to 0.
    tick(1, 8'hFF, 0, 8'h00, 3'd0, 0, 0);
    tick(1, 8'hFF, 0, 8'h00, 3'd0, 0, 0);
    tick(0, 8'hFF, 0, 8'h01, 3'd0, 1, 0);
    tick(1, 8'h00, 0, 8'h00, 3'd0, 0, 0);

    // Fairness: 0,2,0,2 with release on the second grant cycle.
    for (int k = 0; k < 2; k++) begin
      tick(0, 8'h05, 0, 8'h01, 3'd0, 1, 0);
      tick(0, 8'h05, 0, 8'h01, 3'd0, 1, 0);
      tick(0, 8'h05, 1, 8'h00, 3'd0, 0, 0);
      tick(0, 8'h05, 0, 8'h04, 3'd2, 1, 0);
      tick(0, 8'h05, 0, 8'h04, 3'd2, 1, 0);
      tick(0, 8'h05, 1, 8'h00, 3'd2, 0, 0);
    end

    // Wrap: serve 6 (ptr -> 7), then 7, then 0.
    tick(0, 8'h40, 0, 8'h40, 3'd6, 1, 0);
    tick(0, 8'h81, 1, 8'h00, 3'd6, 0, 0);
    tick(0, 8'h81, 0, 8'h80, 3'd7, 1, 0);
    tick(0, 8'h81, 1, 8'h00, 3'd7, 0, 0);
    tick(0, 8'h81, 0, 8'h01, 3'd0, 1, 0);
    tick(0, 8'h00, 1, 8'h00, 3'd0, 0, 0);

    // Timeout: 16 grant cycles, revoke with a one-cycle pulse, re-grant to 3.
    for (int k = 0; k < 16; k++) tick(0, 8'h08, 0, 8'h08, 3'd3, 1, 0);
    tick(0, 8'h08, 0, 8'h00, 3'd3, 0, 1);
    tick(0, 8'h08, 0, 8'h08, 3'd3, 1, 0);
    tick(0, 8'h08, 1, 8'h00, 3'd3, 0, 0);

    // Request drop by holder 5 on its third grant cycle; ptr must land on 6.
    tick(0, 8'h20, 0, 8'h20, 3'd5, 1, 0);
    tick(0, 8'h20, 0, 8'h20, 3'd5, 1, 0);
    tick(0, 8'h20, 0, 8'h20, 3'd5, 1, 0);
    tick(0, 8'h00, 0, 8'h00, 3'd5, 0, 0);
    tick(0, 8'hE1, 0, 8'h40, 3'd6, 1, 0);
    tick(0, 8'h00, 1, 8'h00, 3'd6, 0, 0);

    // Release coinciding with the hold limit: no timeout pulse afterwards.
    for (int k = 0; k < 16; k++) tick(0, 8'h02, 0, 8'h02, 3'd1, 1, 0);
    tick(0, 8'h02, 1, 8'h00, 3'd1, 0, 0);
    tick(0, 8'h00, 0, 8'h00, 3'd1, 0, 0);

    // Mid-grant reset clears the grant and returns ptr to 0.
    tick(0, 8'h04, 0, 8'h04, 3'd2, 1, 0);
    tick(0, 8'h04, 0, 8'h04, 3'd2, 1, 0);
    tick(1, 8'h04, 0, 8'h00, 3'd0, 0, 0);
    tick(0, 8'h09, 0, 8'h01, 3'd0, 1, 0);
    tick(0, 8'h09, 1, 8'h00, 3'd0, 0, 0);

    repeat (10) begin
      if (sb.size() == 0) break;
      @(negedge clk);
      #1;
    end
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending, want 0", sb.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
